// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : MEM-stage controller: issues the dcache request from EX/MEM,
//            stalls the front of the pipe on a miss, registers MEM/WB, and
//            raises the sticky halt.
// Revision : 1.0
// ============================================================================
module mem_stage_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ex_valid,
  input  logic             ex_dREN,
  input  logic             ex_dWEN,
  input  logic [31:0]      ex_portOut,
  input  logic [31:0]      ex_portB_fwd,
  input  logic             ex_regWr,
  input  logic             ex_memToReg,
  input  logic [4:0]       ex_regDst,
  input  logic [31:0]      ex_pc_add4,
  input  logic             ex_halt,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic             mem_stall,
  output logic             wb_valid,
  output logic             wb_regWr,
  output logic [4:0]       wb_regDst,
  output logic [31:0]      wb_data,
  output logic [31:0]      wb_pc_add4,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               wb_valid_q, wb_valid_d;
  logic               wb_regWr_q, wb_regWr_d;
  logic [4:0]         wb_regDst_q, wb_regDst_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [31:0]        wb_pc_add4_q, wb_pc_add4_d;
  logic               halt_q, halt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               w_valid;
  logic               w_halted;
  logic               w_req;
  logic               w_stall;
  logic               w_retire;

  // EX/MEM contents are ignored while reset is held, so nothing leaks out.
  assign w_valid  = ex_valid & ~RST;
  assign w_halted = (state_q == HALTED);
  assign w_req    = w_valid & (ex_dREN | ex_dWEN) & ~w_halted;
  assign w_stall  = w_req & ~dhit;
  assign w_retire = w_valid & ~w_stall & ~w_halted;

  assign dmemREN   = w_req & ex_dREN;
  assign dmemWEN   = w_req & ex_dWEN & ~ex_dREN;
  assign dmemaddr  = {ex_portOut[31:2], 2'b00};
  assign dmemstore = ex_portB_fwd;
  assign mem_stall = w_stall;

  always_comb begin
    state_d      = state_q;
    wb_valid_d   = 1'b0;
    wb_regWr_d   = 1'b0;
    wb_regDst_d  = wb_regDst_q;
    wb_data_d    = wb_data_q;
    wb_pc_add4_d = wb_pc_add4_q;
    stall_cnt_d  = stall_cnt_q;

    // A halt carrying a memory op only halts once that access retires.
    case (state_q)
      HALTED:  state_d = HALTED;
      default: begin
        if (w_retire && ex_halt) begin
          state_d = HALTED;
        end else if (w_stall) begin
          state_d = WAIT;
        end else begin
          state_d = RUN;
        end
      end
    endcase

    if (w_retire) begin
      wb_valid_d   = 1'b1;
      wb_regWr_d   = ex_regWr & ~ex_halt;
      wb_regDst_d  = ex_regDst;
      wb_data_d    = ex_memToReg ? dmemload : ex_portOut;
      wb_pc_add4_d = ex_pc_add4;
    end

    halt_d = halt_q | (state_d == HALTED);

    if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RUN;
      wb_valid_q   <= 1'b0;
      wb_regWr_q   <= 1'b0;
      wb_regDst_q  <= 5'd0;
      wb_data_q    <= 32'd0;
      wb_pc_add4_q <= 32'd0;
      halt_q       <= 1'b0;
      stall_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      wb_valid_q   <= wb_valid_d;
      wb_regWr_q   <= wb_regWr_d;
      wb_regDst_q  <= wb_regDst_d;
      wb_data_q    <= wb_data_d;
      wb_pc_add4_q <= wb_pc_add4_d;
      halt_q       <= halt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_regWr     = wb_regWr_q;
  assign wb_regDst    = wb_regDst_q;
  assign wb_data      = wb_data_q;
  assign wb_pc_add4   = wb_pc_add4_q;
  assign halt         = halt_q;
  assign stall_cycles = stall_cnt_q;

endmodule
`default_nettype wire
